inference_sequencer: RTL and testbench
======================================

INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 Parameters: DATA_W, default 19, sample/command word width; LEN_W, default 8, width of length fields and counters.
REQ-002 Reset rstn, synchronous, active-low; clock clk.
REQ-003 Ports, clock and reset first:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start_i  in  1  begin one frame
- cfg_frame_len  in  LEN_W  sample words to load
- cfg_read_len  in  LEN_W  read-timer length
- cfg_count_len  in  LEN_W  count-window length
- s_valid  in  1  sample word valid
- s_data  in  DATA_W  sample word
- s_ready  out  1  sample word accepted
- opcode_o  out  2  to datapath: 0 idle, 1 write, 2 info
- data_o  out  DATA_W  to datapath data_in
- status_i  in  2  from datapath: 0 idle, 1 busy, 2 idle with result
- result_i  in  4  from datapath
- res_valid  out  1  result held
- res_data  out  4  captured result
- res_settled  out  1  result was valid (status 2)
- res_timeout  out  1  watchdog fired
- res_ready  in  1  result consumed
- busy_o  out  1  state != IDLE

Function
REQ-004 States IDLE, LOAD, ISSUE, ARM, WAIT, DONE; encoding free.
REQ-005 IDLE: s_ready=0; start_i=1 latches all cfg_* inputs; next state LOAD if cfg_frame_len!=0, else ISSUE; start_i ignored outside IDLE.
REQ-006 LOAD: s_ready=1; each s_valid&&s_ready beat increments an LEN_W beat counter; beat in cycle n drives opcode_o=1, data_o=s_data in cycle n+1 (registered); opcode_o=0, data_o=0 in cycles with no beat.
REQ-007 LOAD -> ISSUE on the beat making count equal latched frame_len; s_ready=0 from the next cycle, so no extra beats are accepted.
REQ-008 ISSUE: opcode_o=2 for exactly one cycle T; data_o[7:0]=read_len, data_o[17:10]=count_len, all other bits 0.
REQ-009 If read_len+count_len > 255, the 8-bit window wraps: ISSUE, ARM and WAIT are skipped, DONE is entered with res_settled=0 and res_timeout=1, and opcode_o stays 0.
REQ-010 ARM: one cycle (T+1), opcode_o=0, status_i ignored.
REQ-011 WAIT: from T+2, stay while status_i==1; on status_i!=1 capture result_i into res_data, set res_settled=(status_i==2), res_timeout=0, and go to DONE.
REQ-012 read_len+count_len==0: status_i never reads 1, so WAIT exits on its first cycle; this is legal.
REQ-013 DONE: res_valid=1 and res_* stable until res_ready=1; res_valid&&res_ready -> IDLE next cycle; start_i in the same cycle is ignored.
REQ-014 opcode_o is 0 in every state except LOAD beats and ISSUE.

Reset
REQ-015 rstn=0 at any clock edge, mid-frame included: state=IDLE, opcode_o=0, data_o=0, s_ready=0, res_valid=0, res_data=0, res_settled=0, res_timeout=0, busy_o=0, counters=0; no partial frame resumes.

Configuration
REQ-016 Macro SEQ_WATCHDOG_EN defined: a 10-bit WAIT cycle counter clears on WAIT entry.
- When the counter reaches read_len+count_len+16, DONE is entered with res_timeout=1, res_settled=0, res_data=0.
REQ-017 Macro SEQ_WATCHDOG_EN undefined: WAIT waits indefinitely; res_timeout is set only by REQ-009.

Verification
REQ-018 frame_len=3, read=3, count=5, s_valid held 1, status_i models the datapath -> three opcode_o=1 cycles, one opcode_o=2 cycle carrying data_o=0x01403, then res_valid with res_settled=1 and res_data=result_i.
REQ-019 frame_len=0, read=0, count=0 -> ISSUE directly after start, WAIT exits on its first cycle, res_settled follows status_i.
REQ-020 read=200, count=100 -> no opcode_o=2, res_valid=1, res_timeout=1.
REQ-021 s_valid toggled every other cycle, frame_len=4 -> exactly 4 write cycles and no 5th accept; res_ready held 0 for 10 cycles -> res_* stable and start_i ignored.
REQ-022 rstn=0 during WAIT -> next cycle all outputs at reset values; a new start completes normally.
REQ-023 SEQ_WATCHDOG_EN defined, status_i stuck at 1, read=2, count=2 -> res_timeout=1 exactly 20 cycles after WAIT entry.

Source files
------------

// File: rtl/inference_sequencer.sv
// -----------------------------------------------------------------------------
// inference_sequencer
//
// Drives one inference frame into a datapath. It streams a block of sample
// words as write commands, issues one info command carrying the read/count
// window lengths, then waits for the datapath to return to a non-busy status.
// It captures the result and holds it until the consumer takes it.
//
// Optional build macro:
//   SEQ_WATCHDOG_EN - bounds the wait for the datapath. When the wait reaches
//                     read_len + count_len + 16 cycles, the frame ends with
//                     res_timeout set. Without it the wait is unbounded.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   start_i              begin one frame (sampled only while idle)
//   cfg_frame_len        number of sample words to load
//   cfg_read_len         read-timer length
//   cfg_count_len        count-window length
//   s_valid/s_data/s_ready  sample word stream (valid/ready handshake)
//   opcode_o, data_o     command to datapath (0 idle, 1 write, 2 info)
//   status_i, result_i   datapath status (0 idle, 1 busy, 2 result) and result
//   res_valid/res_ready  result handshake
//   res_data             captured result
//   res_settled          the datapath ended with status 2
//   res_timeout          the window wrapped or the watchdog fired
//   busy_o               a frame is in progress
// -----------------------------------------------------------------------------
module inference_sequencer #(
    parameter int DATA_W = 19,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  cfg_frame_len,
    input  logic [LEN_W-1:0]  cfg_read_len,
    input  logic [LEN_W-1:0]  cfg_count_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [1:0]        opcode_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [1:0]        status_i,
    input  logic [3:0]        result_i,
    output logic              res_valid,
    output logic [3:0]        res_data,
    output logic              res_settled,
    output logic              res_timeout,
    input  logic              res_ready,
    output logic              busy_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_ARM   = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_INFO  = 2'd2;

    localparam logic [1:0] STAT_BUSY   = 2'd1;
    localparam logic [1:0] STAT_RESULT = 2'd2;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    // Info command word: read length in [7:0], count length in [17:10].
    function automatic logic [DATA_W-1:0] info_word(input logic [LEN_W-1:0] rd,
                                                    input logic [LEN_W-1:0] cnt);
        logic [DATA_W-1:0] w;
        w        = {DATA_W{1'b0}};
        w[7:0]   = 8'(rd);
        w[17:10] = 8'(cnt);
        return w;
    endfunction

    // Full-width window sum; anything above 255 cannot be encoded in 8 bits.
    function automatic logic [9:0] window_sum(input logic [LEN_W-1:0] rd,
                                              input logic [LEN_W-1:0] cnt);
        return 10'(rd) + 10'(cnt);
    endfunction

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [LEN_W-1:0]  frame_len_r;
    logic [LEN_W-1:0]  read_len_r;
    logic [LEN_W-1:0]  count_len_r;
    logic [LEN_W-1:0]  beat_cnt_r;
    logic              s_ready_r;
    logic [1:0]        opcode_r;
    logic [DATA_W-1:0] data_r;
    logic              res_valid_r;
    logic [3:0]        res_data_r;
    logic              res_settled_r;
    logic              res_timeout_r;
    logic              busy_r;

    logic [9:0]        cfg_sum_s;
    logic [9:0]        lat_sum_s;
    logic              cfg_wrap_s;
    logic              lat_wrap_s;
    logic              beat_s;
    logic              last_beat_s;
    logic              wd_fire_s;

    assign cfg_sum_s   = window_sum(cfg_read_len, cfg_count_len);
    assign lat_sum_s   = window_sum(read_len_r, count_len_r);
    assign cfg_wrap_s  = (cfg_sum_s > 10'd255);
    assign lat_wrap_s  = (lat_sum_s > 10'd255);
    assign beat_s      = (state_r == ST_LOAD) && s_valid && s_ready_r;
    assign last_beat_s = beat_s && ((beat_cnt_r + LEN_ONE) == frame_len_r);

`ifdef SEQ_WATCHDOG_EN
    logic [9:0] wd_cnt_r;

    // Fires on the cycle whose increment would reach the limit, so the
    // timeout becomes visible exactly limit cycles after WAIT entry.
    assign wd_fire_s = ((wd_cnt_r + 10'd1) == (lat_sum_s + 10'd16));

    // WAIT cycle counter, cleared while ARM hands over to WAIT.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wd_cnt_r <= 10'd0;
        end else if (state_r == ST_ARM) begin
            wd_cnt_r <= 10'd0;
        end else if (state_r == ST_WAIT) begin
            wd_cnt_r <= wd_cnt_r + 10'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end
`else
    assign wd_fire_s = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!start_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (cfg_frame_len != LEN_ZERO) begin
                    state_nxt_s = ST_LOAD;
                end else if (cfg_wrap_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            // LOAD ends one cycle after the last beat, once s_ready has dropped,
            // so the last write and the info command land on separate cycles.
            ST_LOAD: begin
                if (s_ready_r) begin
                    state_nxt_s = ST_LOAD;
                end else if (lat_wrap_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_ARM;
            ST_ARM:   state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if ((status_i != STAT_BUSY) || wd_fire_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, configuration latches, command outputs and result registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r       <= ST_IDLE;
            frame_len_r   <= LEN_ZERO;
            read_len_r    <= LEN_ZERO;
            count_len_r   <= LEN_ZERO;
            beat_cnt_r    <= LEN_ZERO;
            s_ready_r     <= 1'b0;
            opcode_r      <= OP_IDLE;
            data_r        <= {DATA_W{1'b0}};
            res_valid_r   <= 1'b0;
            res_data_r    <= 4'd0;
            res_settled_r <= 1'b0;
            res_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            // Command bus idles unless a beat or the info command drives it.
            opcode_r <= OP_IDLE;
            data_r   <= {DATA_W{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        frame_len_r   <= cfg_frame_len;
                        read_len_r    <= cfg_read_len;
                        count_len_r   <= cfg_count_len;
                        beat_cnt_r    <= LEN_ZERO;
                        s_ready_r     <= (cfg_frame_len != LEN_ZERO);
                        res_data_r    <= 4'd0;
                        res_settled_r <= 1'b0;
                        res_timeout_r <= 1'b0;
                        if (cfg_frame_len == LEN_ZERO) begin
                            if (cfg_wrap_s) begin
                                res_valid_r   <= 1'b1;
                                res_timeout_r <= 1'b1;
                            end else begin
                                opcode_r <= OP_INFO;
                                data_r   <= info_word(cfg_read_len, cfg_count_len);
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (beat_s) begin
                        opcode_r   <= OP_WRITE;
                        data_r     <= s_data;
                        beat_cnt_r <= beat_cnt_r + LEN_ONE;
                        if (last_beat_s) begin
                            s_ready_r <= 1'b0;
                        end
                    end else if (!s_ready_r) begin
                        if (lat_wrap_s) begin
                            res_valid_r   <= 1'b1;
                            res_timeout_r <= 1'b1;
                        end else begin
                            opcode_r <= OP_INFO;
                            data_r   <= info_word(read_len_r, count_len_r);
                        end
                    end
                end
                ST_WAIT: begin
                    if (status_i != STAT_BUSY) begin
                        res_valid_r   <= 1'b1;
                        res_data_r    <= result_i;
                        res_settled_r <= (status_i == STAT_RESULT);
                        res_timeout_r <= 1'b0;
                    end else if (wd_fire_s) begin
                        res_valid_r   <= 1'b1;
                        res_data_r    <= 4'd0;
                        res_settled_r <= 1'b0;
                        res_timeout_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s_ready     = s_ready_r;
    assign opcode_o    = opcode_r;
    assign data_o      = data_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_settled = res_settled_r;
    assign res_timeout = res_timeout_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_inference_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for inference_sequencer. Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_inference_sequencer;

    localparam int DATA_W = 19;
    localparam int LEN_W  = 8;

    logic              clk;
    logic              rstn;
    logic              start_i;
    logic [LEN_W-1:0]  cfg_frame_len;
    logic [LEN_W-1:0]  cfg_read_len;
    logic [LEN_W-1:0]  cfg_count_len;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [1:0]        opcode_o;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        status_i;
    logic [3:0]        result_i;
    logic              res_valid;
    logic [3:0]        res_data;
    logic              res_settled;
    logic              res_timeout;
    logic              res_ready;
    logic              busy_o;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int info_cnt = 0;

    inference_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start_i       (start_i),
        .cfg_frame_len (cfg_frame_len),
        .cfg_read_len  (cfg_read_len),
        .cfg_count_len (cfg_count_len),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .opcode_o      (opcode_o),
        .data_o        (data_o),
        .status_i      (status_i),
        .result_i      (result_i),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_settled   (res_settled),
        .res_timeout   (res_timeout),
        .res_ready     (res_ready),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts command cycles as seen by the datapath on each rising edge.
    always @(posedge clk) begin
        if (opcode_o == 2'd1) wr_cnt = wr_cnt + 1;
        if (opcode_o == 2'd2) info_cnt = info_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        checks++;
        if ({opcode_o, data_o, s_ready, res_valid, res_data, res_settled, res_timeout, busy_o} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {opcode_o, data_o, s_ready, res_valid, res_data, res_settled, res_timeout, busy_o});
        end
        rstn = 1'b1;
        step();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_basic_frame();
        int wr_base;
        int info_base;
        wr_base = wr_cnt;
        info_base = info_cnt;
        cfg_frame_len = 8'd3; cfg_read_len = 8'd3; cfg_count_len = 8'd5;
        status_i = 2'd0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        checks++;
        if ({s_ready, busy_o, opcode_o} !== 4'b1100) begin
            errors++;
            $display("FAIL basic_load_entry: got %b expected 1100", {s_ready, busy_o, opcode_o});
        end
        s_valid = 1'b1; s_data = 19'h11111;
        step();
        checks++;
        if ({opcode_o, data_o} !== {2'd1, 19'h11111}) begin
            errors++;
            $display("FAIL basic_write0: got %h/%h expected 1/11111", opcode_o, data_o);
        end
        s_data = 19'h22222;
        step();
        checks++;
        if ({opcode_o, data_o} !== {2'd1, 19'h22222}) begin
            errors++;
            $display("FAIL basic_write1: got %h/%h expected 1/22222", opcode_o, data_o);
        end
        s_data = 19'h33333;
        step();
        checks++;
        if ({opcode_o, data_o, s_ready} !== {2'd1, 19'h33333, 1'b0}) begin
            errors++;
            $display("FAIL basic_write2: got %h/%h/%b expected 1/33333/0", opcode_o, data_o, s_ready);
        end
        s_data = 19'h44444;
        step();
        checks++;
        if ({opcode_o, data_o} !== {2'd2, 19'h01403}) begin
            errors++;
            $display("FAIL basic_info: got %h/%h expected 2/01403", opcode_o, data_o);
        end
        s_valid = 1'b0;
        step();
        checks++;
        if ({opcode_o, res_valid} !== 3'b000) begin
            errors++;
            $display("FAIL basic_arm: got %b expected 000", {opcode_o, res_valid});
        end
        status_i = 2'd1;
        step();
        step();
        step();
        checks++;
        if ({res_valid, busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL basic_wait_busy: got %b expected 01", {res_valid, busy_o});
        end
        status_i = 2'd2; result_i = 4'hA;
        step();
        status_i = 2'd0; result_i = 4'h0;
        checks++;
        if ({res_valid, res_data, res_settled, res_timeout} !== {1'b1, 4'hA, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got %b expected 1101010",
                     {res_valid, res_data, res_settled, res_timeout});
        end
        checks++;
        if ((wr_cnt - wr_base) != 3 || (info_cnt - info_base) != 1) begin
            errors++;
            $display("FAIL basic_cmd_counts: got %0d writes %0d infos expected 3 and 1",
                     wr_cnt - wr_base, info_cnt - info_base);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if ({res_valid, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL basic_release: got %b expected 00", {res_valid, busy_o});
        end
    endtask

    task automatic test_zero_window();
        for (int pass = 0; pass < 2; pass++) begin
            cfg_frame_len = 8'd0; cfg_read_len = 8'd0; cfg_count_len = 8'd0;
            status_i = (pass == 0) ? 2'd2 : 2'd0;
            result_i = (pass == 0) ? 4'h5 : 4'h7;
            start_i = 1'b1;
            step();
            start_i = 1'b0;
            checks++;
            if ({opcode_o, data_o, busy_o} !== {2'd2, 19'h00000, 1'b1}) begin
                errors++;
                $display("FAIL zero_issue pass%0d: got %h/%h/%b expected 2/00000/1",
                         pass, opcode_o, data_o, busy_o);
            end
            step();
            step();
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_wait_first pass%0d: got %b expected 0", pass, res_valid);
            end
            step();
            checks++;
            if ({res_valid, res_data, res_settled, res_timeout} !==
                {1'b1, (pass == 0) ? 4'h5 : 4'h7, (pass == 0) ? 1'b1 : 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL zero_result pass%0d: got %b", pass,
                         {res_valid, res_data, res_settled, res_timeout});
            end
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
        end
    endtask

    task automatic test_wrap();
        int info_base;
        info_base = info_cnt;
        cfg_frame_len = 8'd0; cfg_read_len = 8'd200; cfg_count_len = 8'd100;
        status_i = 2'd1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        checks++;
        if ({res_valid, res_settled, res_timeout, opcode_o} !== 5'b10100) begin
            errors++;
            $display("FAIL wrap_result: got %b expected 10100",
                     {res_valid, res_settled, res_timeout, opcode_o});
        end
        checks++;
        if ((info_cnt - info_base) != 0) begin
            errors++;
            $display("FAIL wrap_no_info: got %0d info cycles expected 0", info_cnt - info_base);
        end
        status_i = 2'd0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_toggle_hold();
        int wr_base;
        wr_base = wr_cnt;
        cfg_frame_len = 8'd4; cfg_read_len = 8'd10; cfg_count_len = 8'd20;
        status_i = 2'd0; result_i = 4'h3; start_i = 1'b1;
        step();
        start_i = 1'b0;
        s_valid = 1'b0;
        for (int i = 0; i < 40 && res_valid !== 1'b1; i++) begin
            s_valid = ~s_valid;
            s_data = 19'(i + 1);
            step();
        end
        s_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL toggle_done_timeout: got res_valid %b expected 1", res_valid);
        end
        checks++;
        if ((wr_cnt - wr_base) != 4) begin
            errors++;
            $display("FAIL toggle_write_count: got %0d expected 4", wr_cnt - wr_base);
        end
        // Hold the result unconsumed while start and inputs wiggle.
        start_i = 1'b1; cfg_frame_len = 8'd0; status_i = 2'd2; result_i = 4'hC;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({res_valid, res_data, res_settled, res_timeout, busy_o} !== 8'b10011001) begin
                errors++;
                $display("FAIL toggle_hold cycle%0d: got %b expected 10011001", i,
                         {res_valid, res_data, res_settled, res_timeout, busy_o});
            end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0; start_i = 1'b0;
        step();
        checks++;
        if ({busy_o, res_valid, opcode_o} !== 4'b0000) begin
            errors++;
            $display("FAIL toggle_start_ignored: got %b expected 0000", {busy_o, res_valid, opcode_o});
        end
        status_i = 2'd0;
    endtask

    task automatic test_reset_in_wait();
        cfg_frame_len = 8'd0; cfg_read_len = 8'd1; cfg_count_len = 8'd1;
        status_i = 2'd1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({busy_o, res_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rstwait_in_wait: got %b expected 10", {busy_o, res_valid});
        end
        rstn = 1'b0;
        step();
        checks++;
        if ({opcode_o, data_o, s_ready, res_valid, res_data, res_settled, res_timeout, busy_o} !== 30'd0) begin
            errors++;
            $display("FAIL rstwait_outputs: got %h expected 0",
                     {opcode_o, data_o, s_ready, res_valid, res_data, res_settled, res_timeout, busy_o});
        end
        rstn = 1'b1; status_i = 2'd0;
        step();
        checks++;
        if ({busy_o, opcode_o} !== 3'b000) begin
            errors++;
            $display("FAIL rstwait_no_resume: got %b expected 000", {busy_o, opcode_o});
        end
        cfg_frame_len = 8'd1; cfg_read_len = 8'd4; cfg_count_len = 8'd1;
        start_i = 1'b1;
        step();
        start_i = 1'b0; s_valid = 1'b1; s_data = 19'h5A5A5;
        step();
        s_valid = 1'b0;
        checks++;
        if ({opcode_o, data_o} !== {2'd1, 19'h5A5A5}) begin
            errors++;
            $display("FAIL rstwait_restart_write: got %h/%h expected 1/5A5A5", opcode_o, data_o);
        end
        step();
        checks++;
        if ({opcode_o, data_o} !== {2'd2, 19'h00404}) begin
            errors++;
            $display("FAIL rstwait_restart_info: got %h/%h expected 2/00404", opcode_o, data_o);
        end
        status_i = 2'd1;
        step();
        step();
        status_i = 2'd2; result_i = 4'h9;
        step();
        status_i = 2'd0;
        checks++;
        if ({res_valid, res_data, res_settled, res_timeout} !== {1'b1, 4'h9, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rstwait_restart_result: got %b expected 1100110",
                     {res_valid, res_data, res_settled, res_timeout});
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_watchdog();
        cfg_frame_len = 8'd0; cfg_read_len = 8'd2; cfg_count_len = 8'd2;
        status_i = 2'd1; result_i = 4'hF; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
`ifdef SEQ_WATCHDOG_EN
        for (int i = 0; i < 19; i++) step();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_early: got res_valid %b expected 0 at 19 cycles", res_valid);
        end
        step();
        checks++;
        if ({res_valid, res_data, res_settled, res_timeout} !== {1'b1, 4'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL watchdog_fire: got %b expected 1000001",
                     {res_valid, res_data, res_settled, res_timeout});
        end
        status_i = 2'd0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
`else
        for (int i = 0; i < 40; i++) step();
        checks++;
        if ({busy_o, res_valid, res_timeout} !== 3'b100) begin
            errors++;
            $display("FAIL nowatchdog_wait: got %b expected 100", {busy_o, res_valid, res_timeout});
        end
        rstn = 1'b0;
        step();
        rstn = 1'b1; status_i = 2'd0;
        step();
`endif
    endtask

    initial begin
        rstn = 1'b0; start_i = 1'b0;
        cfg_frame_len = 8'd0; cfg_read_len = 8'd0; cfg_count_len = 8'd0;
        s_valid = 1'b0; s_data = 19'd0;
        status_i = 2'd0; result_i = 4'd0; res_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_zero_window();
        test_wrap();
        test_toggle_hold();
        test_reset_in_wait();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
